uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 138 +++++++++++++
 tb/tb_uart_tx_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding four byte requesters into one UART transmit engine,
// with an inter-frame gap, a per-frame watchdog and a sticky timeout flag.
module uart_tx_arb #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned GAP_CYC = 16,
    parameter int unsigned TMO_CYC = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          req_valid_i,
    input  logic [4*DATA_W-1:0] req_data_i,
    output logic [3:0]          req_ready_o,
    output logic                tx_start_o,
    output logic [DATA_W-1:0]   tx_data_o,
    input  logic                tx_busy_i,
    output logic [1:0]          grant_id_o,
    output logic                arb_busy_o,
    output logic                tmo_err_o,
    input  logic                err_clr_i
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_e;

    localparam int unsigned      GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [15:0]      TMO_LAST = 16'(TMO_CYC - 1);

    state_e              state_q;
    logic [3:0]          req_ready_q;
    logic                tx_start_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic [1:0]          grant_q;
    logic [1:0]          last_q;
    logic                tmo_q;
    logic [15:0]         wdog_q;
    logic [GAP_W-1:0]    gap_q;

    logic [1:0]          win_d;
    logic                any_d;
    logic                wdog_hit;

    // Search order is last+1, last+2, last+3, last; walking it backwards lets the
    // nearest valid requester overwrite any farther one.
    always_comb begin
        logic [1:0] idx;
        win_d = last_q;
        any_d = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            idx = last_q + 2'(k);
            if (req_valid_i[idx]) begin
                win_d = idx;
                any_d = 1'b1;
            end
        end
    end

    assign wdog_hit = (wdog_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            grant_q     <= '0;
            last_q      <= 2'd3;
            tmo_q       <= 1'b0;
            wdog_q      <= '0;
            gap_q       <= '0;
        end else begin
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            // NOTE: a later non-blocking assignment to the same register in this block
            // overrides this one, which is how a timeout set beats a same-cycle clear.
            if (err_clr_i) tmo_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (any_d) begin
                        req_ready_q <= 4'b0001 << win_d;
                        tx_data_q   <= req_data_i[win_d*DATA_W +: DATA_W];
                        grant_q     <= win_d;
                        last_q      <= win_d;
                        wdog_q      <= '0;
                        state_q     <= START;
                    end
                end
                // Two cycles: ready pulse first, then the engine start pulse.
                START: begin
                    if (!tx_start_q) tx_start_q <= 1'b1;
                    else             state_q    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    wdog_q <= wdog_q + 16'd1;
                    if (wdog_hit) begin
                        tmo_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (tx_busy_i) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    wdog_q <= wdog_q + 16'd1;
                    if (wdog_hit) begin
                        tmo_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (!tx_busy_i) begin
                        gap_q   <= '0;
                        state_q <= (GAP_CYC > 0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign tx_start_o  = tx_start_q;
    assign tx_data_o   = tx_data_q;
    assign grant_id_o  = grant_q;
    assign arb_busy_o  = (state_q != IDLE);
    assign tmo_err_o   = tmo_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: one build with a 16-cycle gap and 100-cycle watchdog,
// one gapless build; expected grants are queued at stimulus time and popped at tx_start.
module tb_uart_tx_arb;

    localparam int GAP_A = 16;
    localparam int TMO_A = 100;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  valid_a, ready_a;
    logic [7:0]  dat_a [4];
    logic [31:0] data_a;
    logic        busy_a, clr_a, start_a, abusy_a, tmo_a;
    logic [7:0]  txd_a;
    logic [1:0]  gid_a;

    logic [3:0]  valid_b, ready_b;
    logic [31:0] data_b;
    logic        busy_b, clr_b, start_b, abusy_b, tmo_b;
    logic [7:0]  txd_b;
    logic [1:0]  gid_b;

    assign data_a = {dat_a[3], dat_a[2], dat_a[1], dat_a[0]};

    uart_tx_arb #(.DATA_W(8), .GAP_CYC(GAP_A), .TMO_CYC(TMO_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(valid_a), .req_data_i(data_a), .req_ready_o(ready_a),
        .tx_start_o(start_a), .tx_data_o(txd_a), .tx_busy_i(busy_a),
        .grant_id_o(gid_a), .arb_busy_o(abusy_a), .tmo_err_o(tmo_a), .err_clr_i(clr_a)
    );

    uart_tx_arb #(.DATA_W(8), .GAP_CYC(0), .TMO_CYC(65535)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(valid_b), .req_data_i(data_b), .req_ready_o(ready_b),
        .tx_start_o(start_b), .tx_data_o(txd_b), .tx_busy_i(busy_b),
        .grant_id_o(gid_b), .arb_busy_o(abusy_b), .tmo_err_o(tmo_b), .err_clr_i(clr_b)
    );

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic pop_check(input string tag, input logic [1:0] gid, input logic [7:0] txd);
        exp_t e;
        check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_gid"}, 32'(gid), 32'(e.id));
            check({tag, "_data"}, 32'(txd), 32'(e.data));
        end
    endtask

    // Ticks until dut_a pulses tx_start (bounded); reports cycles taken and the ready seen.
    task automatic wait_start_a(output int n, output logic [3:0] rdy);
        n   = 0;
        rdy = '0;
        while (start_a !== 1'b1 && n < 300) begin
            tick();
            n++;
            if (ready_a !== 4'b0) rdy = ready_a;
        end
        check("start_seen_a", 32'(start_a), 32'd1);
    endtask

    initial begin
        #100us;
        $display("FAIL bench_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int         n, fall, bad_start, bad_ready;
        logic [3:0] rdy;
        logic [1:0] id;

        valid_a = '0; busy_a = 1'b0; clr_a = 1'b0;
        valid_b = '0; busy_b = 1'b0; clr_b = 1'b0; data_b = '0;
        for (int i = 0; i < 4; i++) dat_a[i] = 8'($urandom);
        rst_n = 1'b0;
        repeat (3) tick();

        check("rst_ready", 32'(ready_a), 32'h0);
        check("rst_start", 32'(start_a), 32'h0);
        check("rst_txd",   32'(txd_a),   32'h0);
        check("rst_gid",   32'(gid_a),   32'h0);
        check("rst_abusy", 32'(abusy_a), 32'h0);
        check("rst_tmo",   32'(tmo_a),   32'h0);

        // Fairness: all four requesters held valid from reset release.
        valid_a = 4'hF;
        tick();
        check("rst_hold_ready", 32'(ready_a), 32'h0);
        rst_n = 1'b1;
        for (int f = 0; f < 8; f++) begin
            id = 2'(f % 4);
            sb.push_back('{id: id, data: dat_a[id]});
            wait_start_a(n, rdy);
            check("fair_ready", 32'(rdy), 32'd1 << id);
            check("fair_spacing", 32'(n), (f == 0) ? 32'd2 : 32'(GAP_A + 3));
            pop_check("fair", gid_a, txd_a);
            dat_a[id] = 8'($urandom);
            busy_a = 1'b1;
            repeat (4) tick();
            busy_a = 1'b0;
            if (f == 7) valid_a = '0;
        end
        n = 0;
        while (abusy_a !== 1'b0 && n < 100) begin tick(); n++; end
        check("fair_drain", 32'(abusy_a), 32'h0);

        // Single request from requester 2, then requester 1 pulsed during the gap only.
        dat_a[2] = 8'hA5;
        valid_a  = 4'b0100;
        sb.push_back('{id: 2'd2, data: 8'hA5});
        tick();
        check("single_ready", 32'(ready_a), 32'h4);
        check("single_nostart", 32'(start_a), 32'h0);
        check("single_abusy", 32'(abusy_a), 32'h1);
        valid_a = '0;
        tick();
        check("single_start", 32'(start_a), 32'h1);
        check("single_ready_drop", 32'(ready_a), 32'h0);
        pop_check("single", gid_a, txd_a);
        busy_a = 1'b1;
        repeat (10) tick();
        busy_a = 1'b0;
        fall = 0; bad_start = 0; bad_ready = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 3) valid_a = 4'b0010;
            if (i == 8) valid_a = '0;
            if (start_a === 1'b1) bad_start++;
            if (ready_a[1] === 1'b1) bad_ready++;
            if (fall == 0 && abusy_a === 1'b0) fall = i;
        end
        check("gap_abusy_fall", 32'(fall), 32'(GAP_A + 1));
        check("gap_no_ready1", 32'(bad_ready), 32'h0);
        check("gap_no_start", 32'(bad_start), 32'h0);
        check("txd_stable", 32'(txd_a), 32'hA5);

        // Timeout: engine never goes busy; requester 3 is next after 2.
        valid_a = 4'hF;
        sb.push_back('{id: 2'd3, data: dat_a[3]});
        wait_start_a(n, rdy);
        check("tmo_ready", 32'(rdy), 32'h8);
        pop_check("tmo", gid_a, txd_a);
        repeat (TMO_A) tick();
        check("tmo_early", 32'(tmo_a), 32'h0);
        check("tmo_early_busy", 32'(abusy_a), 32'h1);
        sb.push_back('{id: 2'd0, data: dat_a[0]});
        tick();
        check("tmo_set", 32'(tmo_a), 32'h1);
        check("tmo_idle", 32'(abusy_a), 32'h0);
        wait_start_a(n, rdy);
        check("tmo_next_ready", 32'(rdy), 32'h1);
        check("tmo_next_lat", 32'(n), 32'd2);
        pop_check("tmo_next", gid_a, txd_a);
        valid_a = '0;
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("tmo_clr", 32'(tmo_a), 32'h0);
        repeat (TMO_A - 1) tick();
        check("tmo2_early", 32'(tmo_a), 32'h0);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("tmo_set_wins", 32'(tmo_a), 32'h1);
        check("tmo2_idle", 32'(abusy_a), 32'h0);

        // Reset during WAIT_DONE.
        valid_a = 4'b0100;
        sb.push_back('{id: 2'd2, data: dat_a[2]});
        wait_start_a(n, rdy);
        pop_check("mid", gid_a, txd_a);
        valid_a = '0;
        busy_a  = 1'b1;
        repeat (3) tick();
        check("mid_in_frame", 32'(abusy_a), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(ready_a), 32'h0);
        check("arst_start", 32'(start_a), 32'h0);
        check("arst_txd",   32'(txd_a),   32'h0);
        check("arst_gid",   32'(gid_a),   32'h0);
        check("arst_abusy", 32'(abusy_a), 32'h0);
        check("arst_tmo",   32'(tmo_a),   32'h0);
        valid_a = 4'hF;
        busy_a  = 1'b0;
        repeat (2) tick();
        check("arst_hold_start", 32'(start_a), 32'h0);
        check("arst_hold_ready", 32'(ready_a), 32'h0);
        rst_n = 1'b1;
        sb.push_back('{id: 2'd0, data: dat_a[0]});
        wait_start_a(n, rdy);
        check("post_rst_ready", 32'(rdy), 32'h1);
        check("post_rst_lat", 32'(n), 32'd2);
        pop_check("post_rst", gid_a, txd_a);
        valid_a = '0;

        // Gapless build: back-to-back frames.
        data_b  = {8'h44, 8'h33, 8'h22, 8'h11};
        valid_b = 4'b0001;
        sb.push_back('{id: 2'd0, data: 8'h11});
        n = 0;
        while (start_b !== 1'b1 && n < 50) begin tick(); n++; end
        check("b_start_seen", 32'(start_b), 32'h1);
        check("b_lat", 32'(n), 32'd2);
        pop_check("b0", gid_b, txd_b);
        valid_b = '0;
        busy_b  = 1'b1;
        repeat (3) tick();
        busy_b  = 1'b0;
        valid_b = 4'b0010;
        sb.push_back('{id: 2'd1, data: 8'h22});
        tick();
        check("b_idle", 32'(abusy_b), 32'h0);
        tick();
        check("b_ready", 32'(ready_b), 32'h2);
        valid_b = '0;
        tick();
        check("b_start2", 32'(start_b), 32'h1);
        pop_check("b1", gid_b, txd_b);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
